// File: rtl/instr_fetch_queue_if.sv
// Fetch-stage bus bundle: instruction-memory req/ack, core-side valid/ready,
// redirect control and halt status.
interface instr_fetch_queue_if;
  logic        mem_req;
  logic [31:0] mem_addr;
  logic        mem_ack;
  logic [31:0] mem_rdata;
  logic        inst_valid;
  logic [31:0] inst;
  logic [31:0] inst_pc;
  logic        inst_ready;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic        halted;

  // Fetch unit side
  modport master (
    output mem_req, mem_addr, inst_valid, inst, inst_pc, halted,
    input  mem_ack, mem_rdata, inst_ready, redirect, redirect_pc
  );

  // Memory / core side
  modport slave (
    input  mem_req, mem_addr, inst_valid, inst, inst_pc, halted,
    output mem_ack, mem_rdata, inst_ready, redirect, redirect_pc
  );
endinterface

// File: rtl/instr_fetch_queue.sv
// Instruction fetch queue: issues one word fetch at a time, buffers {pc, instr}
// pairs in a DEPTH-entry FIFO, handles PC redirects and stops after a HALT word.
module instr_fetch_queue #(
  parameter int unsigned DEPTH    = 4,
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input logic               clk,
  input logic               rst,
  instr_fetch_queue_if.master bus
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

  typedef enum logic [1:0] {ISSUE, WAIT, DRAIN, HALT} state_t;

  state_t        state, state_next;
  logic [31:0]   fetch_pc, fetch_pc_next;
  logic [31:0]   req_addr;
  logic [31:0]   fifo_pc    [DEPTH];
  logic [31:0]   fifo_instr [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [CW-1:0] count;
  logic          issue, req, push, pop, head_valid;
  logic [31:0]   addr;

  // Request/accept decode and next-state logic; redirect overrides everything
  always_comb begin
    state_next    = state;
    fetch_pc_next = fetch_pc;
    head_valid    = (count != '0);
    issue         = !rst && (state == ISSUE) && (count < DEPTH_C);
    req           = issue || (!rst && ((state == WAIT) || (state == DRAIN)));
    addr          = (state == ISSUE) ? fetch_pc : req_addr;
    push          = bus.mem_ack && (issue || (state == WAIT)) && !bus.redirect;
    pop           = head_valid && bus.inst_ready;

    case (state)
      ISSUE, WAIT: begin
        if (issue || (state == WAIT)) begin
          if (bus.mem_ack) begin
            state_next    = (bus.mem_rdata == '0) ? HALT : ISSUE;
            fetch_pc_next = fetch_pc + 32'd4;
          end else begin
            state_next = WAIT;
          end
        end
      end
      DRAIN: begin
        if (bus.mem_ack) state_next = ISSUE;
      end
      HALT: state_next = HALT;
      default: state_next = ISSUE;
    endcase

    // A request left unanswered by the redirect cycle must still be absorbed,
    // so its ack is discarded in DRAIN while mem_addr keeps the old address.
    if (bus.redirect) begin
      fetch_pc_next = bus.redirect_pc & ~32'd3;
      state_next    = (req && !bus.mem_ack) ? DRAIN : ISSUE;
    end
  end

  // Drive the bus outputs from the internal decode and FIFO head
  always_comb begin
    bus.mem_req    = req;
    bus.mem_addr   = addr;
    bus.inst_valid = head_valid;
    bus.inst       = fifo_instr[rd_ptr];
    bus.inst_pc    = fifo_pc[rd_ptr];
    bus.halted     = (state == HALT);
  end

  // Fetch control registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= ISSUE;
      fetch_pc <= RESET_PC;
      req_addr <= RESET_PC;
    end else begin
      state    <= state_next;
      fetch_pc <= fetch_pc_next;
      if (issue) req_addr <= fetch_pc;
    end
  end

  // FIFO storage write port
  always_ff @(posedge clk) begin
    if (push) begin
      fifo_pc[wr_ptr]    <= fetch_pc;
      fifo_instr[wr_ptr] <= bus.mem_rdata;
    end
  end

  // FIFO pointers and occupancy; redirect flushes
  always_ff @(posedge clk) begin
    if (rst || bus.redirect) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: tb/tb_instr_fetch_queue.sv
// Directed bench for instr_fetch_queue with a latency-programmable memory model.
module tb_instr_fetch_queue;

  logic clk = 1'b0;
  logic rst = 1'b1;
  instr_fetch_queue_if bus();

  int unsigned vectors     = 0;
  int unsigned miscompares = 0;

  int unsigned lat       = 0;
  logic        halt_en   = 1'b0;
  logic [31:0] halt_addr = '0;
  logic [31:0] waitcnt   = '0;

  always #5 clk = ~clk;

  instr_fetch_queue #(.DEPTH(4), .RESET_PC(32'h0000_0000)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  function automatic logic [31:0] instr_of(input logic [31:0] a);
    return {a[15:0] ^ 16'h5A5A, 16'h0013};
  endfunction

  // Memory model: ack after `lat` cycles of an outstanding request
  always_ff @(posedge clk) begin
    if (bus.mem_req && !bus.mem_ack) waitcnt <= waitcnt + 32'd1;
    else                             waitcnt <= '0;
  end

  assign bus.mem_ack   = bus.mem_req && (waitcnt >= lat);
  assign bus.mem_rdata = (halt_en && bus.mem_addr == halt_addr) ? 32'h0 : instr_of(bus.mem_addr);

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(negedge clk);
  endtask

  initial begin
    bus.inst_ready  = 1'b1;
    bus.redirect    = 1'b0;
    bus.redirect_pc = '0;

    // 1: reset state, zero-wait streaming
    step();
    chk("rst_mem_req", 32'(bus.mem_req), 32'd0);
    chk("rst_valid", 32'(bus.inst_valid), 32'd0);
    chk("rst_halted", 32'(bus.halted), 32'd0);
    rst = 1'b0;
    #1;
    chk("first_req", 32'(bus.mem_req), 32'd1);
    chk("first_addr", bus.mem_addr, 32'h0);
    for (int i = 0; i < 6; i++) begin
      step();
      chk("stream_valid", 32'(bus.inst_valid), 32'd1);
      chk("stream_pc", bus.inst_pc, 32'(4 * i));
      chk("stream_inst", bus.inst, instr_of(32'(4 * i)));
    end

    // 2: backpressure fills exactly DEPTH entries, then resumes without loss
    bus.inst_ready = 1'b0;
    step(); step();
    chk("bp_req_cnt3", 32'(bus.mem_req), 32'd1);
    step();
    chk("bp_req_full", 32'(bus.mem_req), 32'd0);
    chk("bp_hold_pc", bus.inst_pc, 32'h14);
    step(); step();
    chk("bp_req_full2", 32'(bus.mem_req), 32'd0);
    chk("bp_hold_pc2", bus.inst_pc, 32'h14);
    chk("bp_hold_inst", bus.inst, instr_of(32'h14));
    bus.inst_ready = 1'b1;
    for (int j = 0; j < 8; j++) begin
      step();
      chk("resume_valid", 32'(bus.inst_valid), 32'd1);
      chk("resume_pc", bus.inst_pc, 32'h18 + 32'(4 * j));
    end

    // 3: 3-cycle memory, redirect while request outstanding
    rst = 1'b1;
    lat = 3;
    step();
    rst = 1'b0;
    #1;
    chk("l3_req_addr", bus.mem_addr, 32'h0);
    step();
    chk("l3_wait_req", 32'(bus.mem_req), 32'd1);
    bus.redirect    = 1'b1;
    bus.redirect_pc = 32'h0000_0103;
    step();
    bus.redirect = 1'b0;
    chk("drain_req", 32'(bus.mem_req), 32'd1);
    chk("drain_addr", bus.mem_addr, 32'h0);
    chk("drain_valid", 32'(bus.inst_valid), 32'd0);
    step();
    chk("drain_ack_addr", bus.mem_addr, 32'h0);
    step();
    chk("redir_req", 32'(bus.mem_req), 32'd1);
    chk("redir_addr", bus.mem_addr, 32'h100);
    step(); step(); step();
    chk("redir_pre_valid", 32'(bus.inst_valid), 32'd0);
    step();
    chk("redir_valid", 32'(bus.inst_valid), 32'd1);
    chk("redir_pc", bus.inst_pc, 32'h100);
    chk("redir_inst", bus.inst, instr_of(32'h100));

    // 4: redirect coincident with ack drops that data
    step(); step(); step();
    chk("coinc_addr", bus.mem_addr, 32'h104);
    chk("coinc_req", 32'(bus.mem_req), 32'd1);
    bus.redirect    = 1'b1;
    bus.redirect_pc = 32'h0000_0300;
    step();
    bus.redirect = 1'b0;
    chk("coinc_next_addr", bus.mem_addr, 32'h300);
    chk("coinc_next_req", 32'(bus.mem_req), 32'd1);
    for (int k = 0; k < 4; k++) begin
      chk("coinc_no_valid", 32'(bus.inst_valid), 32'd0);
      step();
    end
    chk("coinc_valid", 32'(bus.inst_valid), 32'd1);
    chk("coinc_pc", bus.inst_pc, 32'h300);

    // 5: HALT word at 0x10, then redirect out of HALT
    rst       = 1'b1;
    lat       = 0;
    halt_en   = 1'b1;
    halt_addr = 32'h10;
    step();
    rst = 1'b0;
    for (int i = 0; i < 4; i++) begin
      step();
      chk("pre_halt_pc", bus.inst_pc, 32'(4 * i));
      chk("pre_halt_halted", 32'(bus.halted), 32'd0);
    end
    step();
    chk("halt_pc", bus.inst_pc, 32'h10);
    chk("halt_inst", bus.inst, 32'h0);
    chk("halt_flag", 32'(bus.halted), 32'd1);
    chk("halt_req", 32'(bus.mem_req), 32'd0);
    for (int i = 0; i < 20; i++) begin
      step();
      chk("halted_req", 32'(bus.mem_req), 32'd0);
      chk("halted_flag", 32'(bus.halted), 32'd1);
      chk("halted_valid", 32'(bus.inst_valid), 32'd0);
    end
    halt_en         = 1'b0;
    bus.redirect    = 1'b1;
    bus.redirect_pc = 32'h0000_0040;
    step();
    bus.redirect = 1'b0;
    chk("unhalt_flag", 32'(bus.halted), 32'd0);
    chk("unhalt_req", 32'(bus.mem_req), 32'd1);
    chk("unhalt_addr", bus.mem_addr, 32'h40);
    step();
    chk("unhalt_pc", bus.inst_pc, 32'h40);

    // 6: PC wraparound, then reset during WAIT
    bus.redirect    = 1'b1;
    bus.redirect_pc = 32'hFFFF_FFFC;
    step();
    bus.redirect = 1'b0;
    chk("wrap_addr", bus.mem_addr, 32'hFFFF_FFFC);
    chk("wrap_flush", 32'(bus.inst_valid), 32'd0);
    step();
    chk("wrap_pc", bus.inst_pc, 32'hFFFF_FFFC);
    chk("wrap_next_addr", bus.mem_addr, 32'h0);
    step();
    chk("wrap_pc0", bus.inst_pc, 32'h0);
    lat            = 3;
    bus.inst_ready = 1'b0;
    step();
    chk("wait_req", 32'(bus.mem_req), 32'd1);
    chk("wait_addr", bus.mem_addr, 32'h4);
    chk("wait_valid", 32'(bus.inst_valid), 32'd1);
    rst = 1'b1;
    step();
    chk("mid_rst_valid", 32'(bus.inst_valid), 32'd0);
    chk("mid_rst_req", 32'(bus.mem_req), 32'd0);
    rst = 1'b0;
    #1;
    chk("post_rst_req", 32'(bus.mem_req), 32'd1);
    chk("post_rst_addr", bus.mem_addr, 32'h0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
